// File: rtl/link_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | link_bridge_if : handshake bundle for both directions of link_bridge.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface link_bridge_if #(
    parameter int A_TO_B_BITWIDTH = 8,
    parameter int B_TO_A_BITWIDTH = 8,
    parameter int DEPTH           = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       a_tx_valid;
    logic                       a_tx_ready;
    logic [A_TO_B_BITWIDTH-1:0] a_tx_data;
    logic                       b_rx_valid;
    logic                       b_rx_ready;
    logic [A_TO_B_BITWIDTH-1:0] b_rx_data;
    logic                       b_tx_valid;
    logic                       b_tx_ready;
    logic [B_TO_A_BITWIDTH-1:0] b_tx_data;
    logic                       a_rx_valid;
    logic                       a_rx_ready;
    logic [B_TO_A_BITWIDTH-1:0] a_rx_data;
    logic [CNT_W-1:0]           ab_count;
    logic [CNT_W-1:0]           ba_count;

    // The bridge itself is the slave; the two link endpoints are the master.
    modport slave (
        input  a_tx_valid, a_tx_data, b_rx_ready,
        input  b_tx_valid, b_tx_data, a_rx_ready,
        output a_tx_ready, b_rx_valid, b_rx_data,
        output b_tx_ready, a_rx_valid, a_rx_data,
        output ab_count, ba_count
    );

    modport master (
        output a_tx_valid, a_tx_data, b_rx_ready,
        output b_tx_valid, b_tx_data, a_rx_ready,
        input  a_tx_ready, b_rx_valid, b_rx_data,
        input  b_tx_ready, a_rx_valid, a_rx_data,
        input  ab_count, ba_count
    );
endinterface
`default_nettype wire

// File: rtl/link_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | link_bridge : two independent circular FIFOs, A-to-B and B-to-A.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module link_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       flush,
    input  wire logic                       tx_valid_i,
    output logic                            tx_ready_o,
    input  wire logic [WIDTH-1:0]           tx_data_i,
    output logic                            rx_valid_o,
    input  wire logic                       rx_ready_i,
    output logic [WIDTH-1:0]                rx_data_o,
    output logic [$clog2(DEPTH+1)-1:0]      count_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Ready is derived only from occupancy, so a full FIFO refuses a push
    // even when a pop frees a slot on the same edge.
    assign w_ready = (count_q != c_FULL);
    assign w_valid = (count_q != '0);
    assign w_push  = tx_valid_i && w_ready;
    assign w_pop   = w_valid && rx_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; the output mux hides stale words.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            mem_q[wr_ptr_q] <= tx_data_i;
        end
    end

    assign tx_ready_o = w_ready;
    assign rx_valid_o = w_valid;
    assign rx_data_o  = w_valid ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
endmodule

module link_bridge #(
    parameter int A_TO_B_BITWIDTH = 8,
    parameter int B_TO_A_BITWIDTH = 8,
    parameter int DEPTH           = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      flush,
    link_bridge_if.slave   bus
);
    link_bridge_fifo #(
        .WIDTH (A_TO_B_BITWIDTH),
        .DEPTH (DEPTH)
    ) u_ab_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .tx_valid_i (bus.a_tx_valid),
        .tx_ready_o (bus.a_tx_ready),
        .tx_data_i  (bus.a_tx_data),
        .rx_valid_o (bus.b_rx_valid),
        .rx_ready_i (bus.b_rx_ready),
        .rx_data_o  (bus.b_rx_data),
        .count_o    (bus.ab_count)
    );

    link_bridge_fifo #(
        .WIDTH (B_TO_A_BITWIDTH),
        .DEPTH (DEPTH)
    ) u_ba_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .tx_valid_i (bus.b_tx_valid),
        .tx_ready_o (bus.b_tx_ready),
        .tx_data_i  (bus.b_tx_data),
        .rx_valid_o (bus.a_rx_valid),
        .rx_ready_i (bus.a_rx_ready),
        .rx_data_o  (bus.a_rx_data),
        .count_o    (bus.ba_count)
    );
endmodule
`default_nettype wire
